// File: rtl/c3lib_scan_ctrl_pkg.sv
// Shared types and op encodings for the c3lib scan-chain shift controller.
package c3lib_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPT,
    UNLOAD,
    RESP
  } scan_ctrl_state_e;

  localparam logic SCAN_OP_EXCHANGE = 1'b0;
  localparam logic SCAN_OP_CAPTURE  = 1'b1;

endpackage

// File: rtl/c3lib_scan_bit_cnt.sv
// Shift-bit counter shared by the load and unload passes; flags the last
// shift cycle of a pass.
module c3lib_scan_bit_cnt #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CHAIN_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/c3lib_scan_chain_ctrl.sv
// Scan-chain shift controller: loads a word into the chain, optionally captures
// and unloads it. Optional macro C3LIB_SCAN_CTRL_PARITY_EN adds rsp_parity.
module c3lib_scan_chain_ctrl
  import c3lib_scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_capture,
  input  logic [CHAIN_LEN-1:0] req_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 busy
`ifdef C3LIB_SCAN_CTRL_PARITY_EN
  ,
  output logic                 rsp_parity
`endif
);

  scan_ctrl_state_e     state_q, state_d;
  logic [CHAIN_LEN-1:0] load_q, load_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;
  logic                 cap_q, cap_d;
  logic                 req_ready_q, req_ready_d;
  logic                 scan_en_q, scan_en_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;
  logic                 cnt_clr, cnt_en, cnt_tc, shift;

  c3lib_scan_bit_cnt #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    unload_d    = unload_q;
    cap_d       = cap_q;
    req_ready_d = req_ready_q;
    scan_en_d   = scan_en_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    shift       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = LOAD;
          load_d      = req_data;
          cap_d       = req_capture;
          cnt_clr     = 1'b1;
          req_ready_d = 1'b0;
          scan_en_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end
      LOAD: begin
        shift  = 1'b1;
        cnt_en = 1'b1;
        load_d = load_q >> 1;
        if (cnt_tc) begin
          scan_en_d = 1'b0;
          if (cap_q == SCAN_OP_CAPTURE) begin
            state_d = CAPT;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      CAPT: begin
        // Load register is already drained, so scan_in stays 0 through UNLOAD.
        cnt_clr   = 1'b1;
        load_d    = '0;
        unload_d  = '0;
        scan_en_d = 1'b1;
        state_d   = UNLOAD;
      end
      UNLOAD: begin
        shift  = 1'b1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          scan_en_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Tail bit enters at the MSB so the first observed bit lands in bit 0.
    if (shift) begin
      unload_d = {scan_out, unload_q[CHAIN_LEN-1:1]};
    end
  end

  // NOTE: the data registers are reset too, since they drive scan_in and rsp_data directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      load_q      <= '0;
      unload_q    <= '0;
      cap_q       <= SCAN_OP_EXCHANGE;
      req_ready_q <= 1'b1;
      scan_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      unload_q    <= unload_d;
      cap_q       <= cap_d;
      req_ready_q <= req_ready_d;
      scan_en_q   <= scan_en_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = load_q[0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = unload_q;
  assign busy      = busy_q;

`ifdef C3LIB_SCAN_CTRL_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if ((state_q == IDLE && req_valid && req_ready_q) || state_q == CAPT) begin
      par_d = 1'b0;
    end else if (shift) begin
      par_d = par_q ^ scan_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign rsp_parity = par_q;
`else
  // Default build carries no parity tracking.
`endif

endmodule

// File: tb/tb_c3lib_scan_chain_ctrl.sv
// Scoreboard bench for c3lib_scan_chain_ctrl driving an 8-flop scan chain model.
module tb_c3lib_scan_chain_ctrl;

  localparam int L = 8;

  typedef struct {
    logic [L-1:0] data;
    logic         par;
    int           lat;
    int           acc;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_capture = 1'b0;
  logic [L-1:0] req_data = '0;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [L-1:0] rsp_data;
  logic         busy;
`ifdef C3LIB_SCAN_CTRL_PARITY_EN
  logic         rsp_parity;
`endif

  logic [L-1:0] chain;
  logic [L-1:0] func_data = '0;
  logic [L-1:0] model_chain = '0;
  sb_t          sb[$];
  int           cyc = 0;
  int           hs_cyc = -100;
  int           force_stall = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  c3lib_scan_chain_ctrl #(.CHAIN_LEN(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_capture (req_capture),
    .req_data    (req_data),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef C3LIB_SCAN_CTRL_PARITY_EN
    ,
    .rsp_parity  (rsp_parity)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scan-reset flops: shift when scan_en, load data_in only on the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (scan_en) begin
      chain <= {scan_in, chain[L-1:1]};
    end else if (busy && !rsp_valid) begin
      chain <= func_data;
    end
  end
  assign scan_out = chain[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference model: an exchange returns the previous contents and leaves the
  // new word; a capture returns data_in and leaves zeros behind.
  task automatic issue(input bit op, input logic [L-1:0] data, input logic [L-1:0] func,
                       input bit hold);
    bit  was_busy;
    int  n;
    sb_t e;
    was_busy    = !req_ready;
    req_valid   = 1'b1;
    req_capture = op;
    req_data    = data;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    func_data = func;
    e.acc = cyc + 1;
    if (op) begin
      e.lat       = 2 * L + 1;
      e.data      = func;
      model_chain = '0;
    end else begin
      e.lat       = L;
      e.data      = model_chain;
      model_chain = data;
    end
    e.par = ^e.data;
    sb.push_back(e);
    if (was_busy) check("accept_after_handshake", e.acc, hs_cyc + 1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin : monitor
    bit           in_rsp;
    logic [L-1:0] held;
    sb_t          e;
    in_rsp    = 1'b0;
    held      = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rsp    = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        if (in_rsp) begin
          check("hold_rsp_valid", rsp_valid, 1);
          check("hold_rsp_data", rsp_data, held);
          check("hold_req_ready", req_ready, 0);
        end else if (rsp_valid) begin
          if (sb.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            e = sb[0];
            check("rsp_latency", cyc - e.acc, e.lat);
            check("rsp_data", rsp_data, e.data);
`ifdef C3LIB_SCAN_CTRL_PARITY_EN
            check("rsp_parity", rsp_parity, e.par);
`endif
          end
          held   = rsp_data;
          in_rsp = 1'b1;
        end
        if (in_rsp && force_stall > 0) begin
          rsp_ready = 1'b0;
          force_stall--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (in_rsp && rsp_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          hs_cyc = cyc + 1;
          in_rsp = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit           op;
    bit           hold;
    logic [L-1:0] d;
    logic [L-1:0] f;

    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_scan_en", scan_en, 0);
    check("reset_scan_in", scan_in, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exchange after reset, then a second exchange returns the first word.
    issue(1'b0, 8'hA5, 8'h00, 1'b0);
    wait_drain();
    issue(1'b0, 8'h3C, 8'h00, 1'b0);
    wait_drain();

    // Capture op: returns data_in and leaves the chain zero-filled.
    issue(1'b1, 8'hFF, 8'h5A, 1'b0);
    wait_drain();
    check("chain_after_capture", chain, 8'h00);

    // Backpressure with a second request pending; parity patterns 07 and 03.
    issue(1'b0, 8'h07, 8'h00, 1'b1);
    force_stall = 5;
    issue(1'b0, 8'h03, 8'h00, 1'b0);
    wait_drain();
    issue(1'b0, 8'h00, 8'h00, 1'b0);
    wait_drain();

    // Reset in LOAD cycle 4 aborts without a response.
    issue(1'b0, 8'hC3, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("load_scan_en", scan_en, 1);
    check("load_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_scan_en", scan_en, 0);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    sb.delete();
    model_chain = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", req_ready, 1);
    issue(1'b0, 8'h5A, 8'h00, 1'b0);
    wait_drain();

    // Back-to-back with req_valid held high across ops.
    issue(1'b0, 8'h96, 8'h00, 1'b1);
    issue(1'b1, 8'h11, 8'hE7, 1'b1);
    issue(1'b0, 8'h42, 8'h00, 1'b0);
    wait_drain();

    // Randomized mix of ops, data and back-to-back holds.
    for (int i = 0; i < 24; i++) begin
      op   = 1'($urandom_range(0, 1));
      hold = (i != 23) && ($urandom_range(0, 1) == 1);
      d    = L'($urandom);
      f    = L'($urandom);
      issue(op, d, f, hold);
      if (!hold) wait_drain();
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
